// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: channel count, widths and FSM states.
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above idx.
// When from_start is set, index 0 is also a candidate (first-channel pick).
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  idx,
  input  logic              from_start,
  output logic [SEL_W-1:0]  next_idx,
  output logic              found
);

  // Scan downward so the lowest qualifying channel is the last one written.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(idx)))) begin
        next_idx = SEL_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 single-bit mux. Steps sel across the enabled
// channels in ascending order, holds each for SETTLE_CYCLES+1 cycles, samples
// mux_out on the last cycle and presents the assembled word over valid/ready.
// Optional: define MUX_SCAN_PARITY_EN to add a registered word_parity output.
//
// state   | meaning
// IDLE    | waiting for start with a non-zero ch_mask
// SETTLE  | sel driven; counting down, sample mux_out at terminal count
// PRESENT | word valid, holding until word_ready
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_out,
  output logic [NUM_CH-1:0] word,
  output logic              word_valid,
`ifdef MUX_SCAN_PARITY_EN
  output logic              word_parity,
`endif
  input  logic              word_ready,
  output logic              busy
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t            state;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_merged;
  logic [CNT_W-1:0]  cnt;

  logic [SEL_W-1:0]  first_idx;
  logic              first_found;
  logic [SEL_W-1:0]  adv_idx;
  logic              adv_found;

  // First enabled channel of the live mask, used at start and at continuous restart.
  mux_scan_next_ch u_first (
    .mask       (ch_mask),
    .idx        ('0),
    .from_start (1'b1),
    .next_idx   (first_idx),
    .found      (first_found)
  );

  // Next enabled channel above the current one, from the mask latched at scan start.
  mux_scan_next_ch u_adv (
    .mask       (mask_q),
    .idx        (sel),
    .from_start (1'b0),
    .next_idx   (adv_idx),
    .found      (adv_found)
  );

  // Shadow word with the current channel's sample merged in.
  always_comb begin
    shadow_merged      = shadow;
    shadow_merged[sel] = mux_out;
  end

  assign busy = (state != IDLE);

  // Scan FSM with registered sel/word/valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask_q      <= '0;
      shadow      <= '0;
      cnt         <= '0;
      sel         <= '0;
      word        <= '0;
      word_valid  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && first_found) begin
            mask_q <= ch_mask;
            shadow <= '0;
            sel    <= first_idx;
            cnt    <= SETTLE_LOAD;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shadow <= shadow_merged;
            if (adv_found) begin
              sel <= adv_idx;
              cnt <= SETTLE_LOAD;
            end else begin
              word        <= shadow_merged;
              word_valid  <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
              word_parity <= ^shadow_merged;
`endif
              state       <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (word_ready) begin
            word_valid <= 1'b0;
            if (cont_mode && first_found) begin
              mask_q <= ch_mask;
              shadow <= '0;
              sel    <= first_idx;
              cnt    <= SETTLE_LOAD;
              state  <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one instance with SETTLE_CYCLES=1 and
// one with SETTLE_CYCLES=0. A behavioural 4:1 mux feeds each from mux_in.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] mux_in;

  logic       start_a, cont_a, ready_a;
  logic [3:0] mask_a;
  logic [1:0] sel_a;
  logic [3:0] word_a;
  logic       valid_a, busy_a;
  logic       mux_out_a;

  logic       start_b, cont_b, ready_b;
  logic [3:0] mask_b;
  logic [1:0] sel_b;
  logic [3:0] word_b;
  logic       valid_b, busy_b;
  logic       mux_out_b;

`ifdef MUX_SCAN_PARITY_EN
  logic       par_a, par_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mux_out_a = mux_in[sel_a];
  assign mux_out_b = mux_in[sel_b];

  mux_scan_ctrl #(.SETTLE_CYCLES(1)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .cont_mode  (cont_a),
    .ch_mask    (mask_a),
    .sel        (sel_a),
    .mux_out    (mux_out_a),
    .word       (word_a),
    .word_valid (valid_a),
`ifdef MUX_SCAN_PARITY_EN
    .word_parity(par_a),
`endif
    .word_ready (ready_a),
    .busy       (busy_a)
  );

  mux_scan_ctrl #(.SETTLE_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .cont_mode  (cont_b),
    .ch_mask    (mask_b),
    .sel        (sel_b),
    .mux_out    (mux_out_b),
    .word       (word_b),
    .word_valid (valid_b),
`ifdef MUX_SCAN_PARITY_EN
    .word_parity(par_b),
`endif
    .word_ready (ready_b),
    .busy       (busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word_a(input string tag, input logic [3:0] exp);
    check(tag, {4'd0, word_a}, {4'd0, exp});
`ifdef MUX_SCAN_PARITY_EN
    check({tag, "_par"}, {7'd0, par_a}, {7'd0, ^exp});
`endif
  endtask

  initial begin
    rst_n = 1'b0; mux_in = 4'b0000;
    start_a = 0; cont_a = 0; ready_a = 0; mask_a = 4'b0000;
    start_b = 0; cont_b = 0; ready_b = 0; mask_b = 4'b0000;
    tick(); tick();
    check("rst_sel",   {6'd0, sel_a}, 8'd0);
    check("rst_word",  {4'd0, word_a}, 8'd0);
    check("rst_valid", {7'd0, valid_a}, 8'd0);
    check("rst_busy",  {7'd0, busy_a}, 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    check("rst_par",   {7'd0, par_a}, 8'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Full scan, SETTLE=1, inputs 1010
    mask_a = 4'b1111; mux_in = 4'b1010; start_a = 1;
    tick();                                   // edge T
    start_a = 0;
    check("full_busy", {7'd0, busy_a}, 8'd1);
    check("full_sel_t0", {6'd0, sel_a}, 8'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("full_sel_t%0d", i), {6'd0, sel_a}, 8'(i / 2));
      check($sformatf("full_novalid_t%0d", i), {7'd0, valid_a}, 8'd0);
    end
    tick();                                   // T+8
    check("full_valid", {7'd0, valid_a}, 8'd1);
    check_word_a("full_word", 4'b1010);

    // Backpressure: 10 cycles of ready=0, then a single handshake
    mux_in = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {7'd0, valid_a}, 8'd1);
      check("bp_word",  {4'd0, word_a}, 8'b1010);
      check("bp_sel",   {6'd0, sel_a}, 8'd3);
      check("bp_busy",  {7'd0, busy_a}, 8'd1);
    end
    ready_a = 1;
    tick();
    ready_a = 0;
    check("hs_valid", {7'd0, valid_a}, 8'd0);
    check("hs_busy",  {7'd0, busy_a}, 8'd0);
    check("hs_sel_hold", {6'd0, sel_a}, 8'd3);
    tick();
    check("hs_single", {7'd0, valid_a}, 8'd0);

    // start with ch_mask=0 is ignored
    mask_a = 4'b0000; start_a = 1;
    tick();
    start_a = 0;
    check("zmask_busy", {7'd0, busy_a}, 8'd0);
    check("zmask_sel",  {6'd0, sel_a}, 8'd3);

    // Sparse mask, SETTLE=0, on second instance
    mask_b = 4'b1001; mux_in = 4'b1111; start_b = 1;
    tick();                                   // T
    start_b = 0;
    check("sparse_sel0", {6'd0, sel_b}, 8'd0);
    tick();                                   // T+1
    check("sparse_sel3", {6'd0, sel_b}, 8'd3);
    check("sparse_novalid", {7'd0, valid_b}, 8'd0);
    tick();                                   // T+2
    check("sparse_valid", {7'd0, valid_b}, 8'd1);
    check("sparse_word", {4'd0, word_b}, 8'b1001);
`ifdef MUX_SCAN_PARITY_EN
    check("sparse_par", {7'd0, par_b}, 8'd0);
`endif
    ready_b = 1;
    tick();
    ready_b = 0;
    check("sparse_hs", {7'd0, valid_b}, 8'd0);
    check("sparse_idle", {7'd0, busy_b}, 8'd0);

    // start and ch_mask change while busy are ignored
    mask_a = 4'b0001; mux_in = 4'b0111; start_a = 1;
    tick();                                   // T
    mask_a = 4'b1111;                         // start still high, mask widened
    tick();                                   // T+1
    check("busy_start_sel", {6'd0, sel_a}, 8'd0);
    tick();                                   // T+2
    start_a = 0;
    check("busy_start_valid", {7'd0, valid_a}, 8'd1);
    check_word_a("busy_start_word", 4'b0001);

    // Reset while a word is pending discards it
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstp_valid", {7'd0, valid_a}, 8'd0);
    check("rstp_word",  {4'd0, word_a}, 8'd0);
    check("rstp_busy",  {7'd0, busy_a}, 8'd0);

    // Handshake with start in PRESENT, cont_mode=0: idles
    mask_a = 4'b0111; mux_in = 4'b0111; start_a = 1;
    tick();
    start_a = 0;
    for (int i = 0; i < 6; i++) tick();       // N=3 -> T+6
    check("par7_valid", {7'd0, valid_a}, 8'd1);
    check_word_a("par7_word", 4'b0111);
    start_a = 1; ready_a = 1;
    tick();
    start_a = 0; ready_a = 0;
    check("hs_start_busy", {7'd0, busy_a}, 8'd0);

    // Continuous mode
    cont_a = 1; mask_a = 4'b0110; mux_in = 4'b0110; start_a = 1;
    tick();                                   // T
    start_a = 0;
    check("cont_sel1", {6'd0, sel_a}, 8'd1);
    for (int i = 0; i < 4; i++) tick();       // T+4
    check("cont_valid1", {7'd0, valid_a}, 8'd1);
    check_word_a("cont_word1", 4'b0110);
    mux_in = 4'b0000; ready_a = 1;
    tick();                                   // H: restart
    ready_a = 0;
    check("cont_restart_valid", {7'd0, valid_a}, 8'd0);
    check("cont_restart_busy",  {7'd0, busy_a}, 8'd1);
    check("cont_restart_sel",   {6'd0, sel_a}, 8'd1);
    tick();                                   // H+1
    cont_a = 0;
    tick(); tick();                           // H+3
    check("cont_novalid2", {7'd0, valid_a}, 8'd0);
    check("cont_sel2", {6'd0, sel_a}, 8'd2);
    tick();                                   // H+4
    check("cont_valid2", {7'd0, valid_a}, 8'd1);
    check_word_a("cont_word2", 4'b0000);
    ready_a = 1;
    tick();
    ready_a = 0;
    check("cont_end_valid", {7'd0, valid_a}, 8'd0);
    check("cont_end_busy",  {7'd0, busy_a}, 8'd0);

    // Reset mid-SETTLE
    mask_a = 4'b1111; mux_in = 4'b1111; start_a = 1;
    tick();
    start_a = 0;
    tick(); tick();
    check("rsts_busy_pre", {7'd0, busy_a}, 8'd1);
    check("rsts_sel_pre",  {6'd0, sel_a}, 8'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rsts_sel",   {6'd0, sel_a}, 8'd0);
    check("rsts_word",  {4'd0, word_a}, 8'd0);
    check("rsts_valid", {7'd0, valid_a}, 8'd0);
    check("rsts_busy",  {7'd0, busy_a}, 8'd0);
    tick();
    check("rsts_stay_idle", {7'd0, busy_a}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer sitting directly upstream of the team's 4:1 single-bit mux.
- Drives the mux's 2-bit select across enabled channels and waits a programmable settle time per channel.
- Samples the mux's 1-bit output for each channel and assembles a 4-bit word.
- Delivers the word downstream over a valid/ready handshake, as a one-shot or continuous scan.

Parameters:
- SETTLE_CYCLES, 1, extra cycles sel is held before sampling (0..15; 0 = sample in the first cycle sel is presented).

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a scan; honoured only in IDLE with ch_mask != 0
- cont_mode  input  1  1 = rescan automatically after each word handshake
- ch_mask  input  4  channel enables; bit i = channel i; sampled at scan start
- sel  output  2  select to mux; index of channel being scanned
- mux_out  input  1  mux output (data_out of the 4:1 mux)
- word  output  4  assembled sample; bit i = channel i; disabled channels read 0
- word_valid  output  1  word available
- word_ready  input  1  downstream accepts word
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: sel=0, word=0, word_valid=0, busy=0, state=IDLE, internal mask/shadow/counter cleared.
- Reset mid-operation: the next edge with rst_n=0 aborts any scan. A pending word is discarded with no handshake.
- States: IDLE, SETTLE, PRESENT.
- IDLE:
  - start=1 and ch_mask!=0: latch ch_mask into an internal mask, clear the shadow word, load sel with the lowest enabled channel, load the counter with SETTLE_CYCLES, go to SETTLE.
  - start=1 and ch_mask==0: ignored; remain in IDLE.
- SETTLE:
  - counter!=0: decrement.
  - counter==0: shadow[sel] <= mux_out.
  - If a higher enabled channel exists, sel <= that channel, reload the counter, stay in SETTLE.
  - Otherwise, word <= shadow with the final bit merged, word_valid <= 1, go to PRESENT.
- Each enabled channel occupies exactly SETTLE_CYCLES+1 cycles. Channels are scanned in ascending index order; disabled channels are skipped with no cycles spent on them.
- Latency: start accepted at edge T → word_valid high at edge T + N*(SETTLE_CYCLES+1), where N = number of enabled channels.
- PRESENT:
  - word and word_valid are held stable until word_ready=1.
  - On handshake, word_valid <= 0. If cont_mode=1, restart the scan using the current ch_mask (skip to IDLE if ch_mask==0); otherwise go to IDLE.
  - No scanning occurs while stalled, so there is no overrun.
- sel holds its last value in IDLE/PRESENT.
- start while busy=1 is ignored.
- ch_mask changes mid-scan are ignored until the next scan start.
- cont_mode is sampled only at handshake. Clearing it mid-scan finishes the current word and then idles.
- Simultaneous handshake and start in PRESENT: start is ignored. Restart is governed by cont_mode only.

Optional Feature:
- Macro MUX_SCAN_PARITY_EN.
- Defined: adds output word_parity (1 bit) = XOR of word. It is registered with word, has the same valid/stability rules, and resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package mux_scan_pkg holds:
  - NUM_CH=4, SEL_W=2, CNT_W=4
  - state enum (IDLE, SETTLE, PRESENT)
- Sub-module mux_scan_next_ch (combinational):
  - Inputs: mask (4) and current index (2), plus a "from_start" flag that includes index 0.
  - Outputs: next enabled index and a found flag.
  - Used for both the first-channel pick and the advance decision.

Test Plan:
- Full scan, SETTLE=1: ch_mask=4'b1111, mux inputs 4'b1010, start at edge T → sel steps 0,1,2,3 for 2 cycles each; word_valid at T+8 with word=4'b1010; ready=1 → valid drops at the next edge, busy=0.
- Sparse mask, SETTLE=0: ch_mask=4'b1001, inputs 4'b1111 → sel visits 0 then 3 only; word=4'b1001 at T+2.
- Backpressure: hold word_ready=0 for 10 cycles after valid → word and valid are stable throughout, sel does not change, busy=1; ready=1 → single handshake.
- Continuous mode: cont_mode=1, ch_mask=4'b0110, inputs toggled between words → successive words 4'b0110 then 4'b0000; clearing cont_mode mid-second-scan idles after that word.
- Corner cases:
  - start with ch_mask=0 → no state change.
  - start while busy → ignored.
  - rst_n=0 mid-SETTLE → all outputs at reset values after one edge.
- With MUX_SCAN_PARITY_EN: word=4'b0111 → word_parity=1; word=4'b0110 → word_parity=0.
